oversample_filter: RTL and testbench

//   Upstream producer for the PID core input port. Averages 2^os consecutive signed
//   ADC samples and emits one offset-binary result, with a one-cycle valid pulse,
//   per completed frame. The output pair (data_out, data_valid_out) drives the PID

---
 rtl/oversample_filter.sv | 125 ++++++++++++
 tb/tb_oversample_filter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/oversample_filter.sv
// oversample_filter: averages 2^os consecutive signed ADC samples. Each completed frame
// produces one offset-binary result and a one-cycle valid strobe. The result feeds the
// PID core input port.
//
// Ports
//   clk_in          system clock
//   reset_n_in      asynchronous active-low reset
//   data_in         signed ADC sample (W_IN bits)
//   data_valid_in   one-cycle strobe per sample
//   os_in           log2 oversample ratio to stage (0 = pass-through)
//   clear_in        synchronous frame abort (zeroes accumulator and counter)
//   update_en_in    qualifies update_in
//   update_in       latches os_in into the pending ratio register
//   data_out        averaged sample, unsigned offset binary; held between frames
//   data_valid_out  one-cycle strobe: data_out is new
//   os_active_out   ratio in force for the current frame
module oversample_filter #(
  parameter int unsigned W_IN  = 18,
  parameter int unsigned W_OUT = 18,
  parameter int unsigned W_OS  = 4
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic [W_IN-1:0]  data_in,
  input  logic             data_valid_in,
  input  logic [W_OS-1:0]  os_in,
  input  logic             clear_in,
  input  logic             update_en_in,
  input  logic             update_in,
  output logic [W_OUT-1:0] data_out,
  output logic             data_valid_out,
  output logic [W_OS-1:0]  os_active_out
);

  // The accumulator holds up to 2^(2^W_OS-1) samples without overflow.
  localparam int unsigned W_ACC = W_IN + 2**W_OS - 1;
  // The counter must represent the terminal count 2^(2^W_OS-1).
  localparam int unsigned W_CNT = 2**W_OS;

  typedef enum logic [0:0] {StAccum, StSend} state_t;

  state_t                   state_q;
  logic [W_OS-1:0]          pending_os_q;
  logic signed [W_ACC-1:0]  acc_q;
  logic [W_CNT-1:0]         cnt_q;

  logic                     accept;
  logic signed [W_ACC-1:0]  sample_ext;
  logic signed [W_ACC-1:0]  sum;
  logic signed [W_IN-1:0]   avg;
  logic [W_OUT-1:0]         avg_word;
  logic [W_OUT-1:0]         out_word;
  logic [W_CNT-1:0]         cnt_next;
  logic [W_CNT-1:0]         ratio;
  logic                     last_sample;
  logic                     load_os;

  assign accept     = data_valid_in & ~clear_in;
  assign sample_ext = {{(W_ACC-W_IN){data_in[W_IN-1]}}, data_in};
  assign sum        = acc_q + sample_ext;
  // Arithmetic shift floors toward -inf. The average always fits back into W_IN bits.
  assign avg        = W_IN'(sum >>> os_active_out);
  assign avg_word   = avg[W_IN-1 -: W_OUT];
  assign out_word   = {~avg_word[W_OUT-1], avg_word[W_OUT-2:0]};
  assign cnt_next   = cnt_q + W_CNT'(1);
  assign ratio      = W_CNT'(1) << os_active_out;
  // Use >= rather than ==. A sample carried in from StSend can leave the counter at 1
  // when the new ratio is 1. That frame must still end on its next sample.
  assign last_sample = (cnt_next >= ratio);
  // Reload only between frames. A sample accepted in StSend opens a frame that takes
  // the fresh ratio.
  assign load_os    = (cnt_q == '0) && ((state_q == StSend) || !accept);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q        <= StAccum;
      pending_os_q   <= '0;
      os_active_out  <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      if (update_in && update_en_in) begin
        pending_os_q <= os_in;
      end
      if (load_os) begin
        os_active_out <= pending_os_q;
      end
      if (clear_in) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= StAccum;
      end else begin
        unique case (state_q)
          StAccum: begin
            if (data_valid_in) begin
              if (last_sample) begin
                data_out       <= out_word;
                data_valid_out <= 1'b1;
                acc_q          <= '0;
                cnt_q          <= '0;
                state_q        <= StSend;
              end else begin
                acc_q <= sum;
                cnt_q <= cnt_next;
              end
            end
          end
          StSend: begin
            state_q <= StAccum;
            // No drop: this sample becomes sample 1 of the next frame.
            if (data_valid_in) begin
              acc_q <= sample_ext;
              cnt_q <= W_CNT'(1);
            end
          end
          default: state_q <= StAccum;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oversample_filter.sv
// Directed bench for oversample_filter. Every expected value is computed by hand.
module tb_oversample_filter;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic [17:0] data_in;
  logic        data_valid_in;
  logic [3:0]  os_in;
  logic        clear_in;
  logic        update_en_in;
  logic        update_in;
  logic [17:0] data_out;
  logic        data_valid_out;
  logic [3:0]  os_active_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  oversample_filter #(.W_IN(18), .W_OUT(18), .W_OS(4)) dut (
    .clk_in         (clk_in),
    .reset_n_in     (reset_n_in),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .os_in          (os_in),
    .clear_in       (clear_in),
    .update_en_in   (update_en_in),
    .update_in      (update_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .os_active_out  (os_active_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sample per call. Returns #1 after the accepting edge.
  task automatic send(input int d);
    logic [31:0] w;
    w = d;
    data_in       = w[17:0];
    data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
  endtask

  // Stage a ratio, then give one idle edge so it loads at a frame boundary.
  task automatic prog(input logic [3:0] os);
    os_in        = os;
    update_en_in = 1'b1;
    update_in    = 1'b1;
    step();
    update_in    = 1'b0;
    update_en_in = 1'b0;
    step();
  endtask

  initial begin
    reset_n_in    = 1'b0;
    data_in       = '0;
    data_valid_in = 1'b0;
    os_in         = '0;
    clear_in      = 1'b0;
    update_en_in  = 1'b0;
    update_in     = 1'b0;
    step();
    step();
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid_out), 32'h0);
    check("rst_os", 32'(os_active_out), 32'h0);
    reset_n_in = 1'b1;
    step();

    // Pass-through with os 0.
    prog(4'd0);
    send(100);
    check("t1_valid", 32'(data_valid_out), 32'h1);
    check("t1_data", 32'(data_out), 32'h20064);
    step();
    check("t1_strobe_one_cycle", 32'(data_valid_out), 32'h0);
    check("t1_hold", 32'(data_out), 32'h20064);

    // Average over 4 samples.
    prog(4'd2);
    check("t2_os", 32'(os_active_out), 32'h2);
    send(10);
    send(11);
    send(12);
    check("t2_no_early", 32'(data_valid_out), 32'h0);
    send(13);
    check("t2_valid", 32'(data_valid_out), 32'h1);
    check("t2_data", 32'(data_out), 32'h2000B);

    // Negative average floors toward -inf.
    prog(4'd1);
    check("t3_os", 32'(os_active_out), 32'h1);
    send(-3);
    check("t3_no_early", 32'(data_valid_out), 32'h0);
    send(-4);
    check("t3_valid", 32'(data_valid_out), 32'h1);
    check("t3_data", 32'(data_out), 32'h1FFFC);
    step();

    // An update without its enable is ignored.
    os_in     = 4'd7;
    update_in = 1'b1;
    step();
    update_in = 1'b0;
    step();
    check("upd_gated", 32'(os_active_out), 32'h1);

    // Clear aborts a frame and discards the concurrent sample.
    prog(4'd3);
    for (int i = 0; i < 5; i++) send(7);
    clear_in      = 1'b1;
    data_in       = 18'd7;
    data_valid_in = 1'b1;
    step();
    clear_in      = 1'b0;
    data_valid_in = 1'b0;
    check("t4_clear_no_strobe", 32'(data_valid_out), 32'h0);
    step();
    check("t4_clear_hold", 32'(data_out), 32'h1FFFC);
    for (int i = 0; i < 7; i++) send(7);
    check("t4_no_early", 32'(data_valid_out), 32'h0);
    send(7);
    check("t4_valid", 32'(data_valid_out), 32'h1);
    check("t4_data", 32'(data_out), 32'h20007);
    step();

    // A mid-frame update takes effect only after the frame completes.
    prog(4'd2);
    send(1);
    send(2);
    os_in        = 4'd0;
    update_en_in = 1'b1;
    update_in    = 1'b1;
    step();
    update_in    = 1'b0;
    update_en_in = 1'b0;
    check("t5_os_held", 32'(os_active_out), 32'h2);
    send(3);
    check("t5_no_early", 32'(data_valid_out), 32'h0);
    send(4);
    check("t5_valid", 32'(data_valid_out), 32'h1);
    check("t5_data", 32'(data_out), 32'h20002);
    check("t5_os_still", 32'(os_active_out), 32'h2);
    step();
    check("t5_os_new", 32'(os_active_out), 32'h0);
    send(5);
    check("t5_pass_valid", 32'(data_valid_out), 32'h1);
    check("t5_pass_data", 32'(data_out), 32'h20005);
    step();
    send(-6);
    check("t5_neg_data", 32'(data_out), 32'h1FFFA);
    step();
    // A sample that lands in the send cycle carries into the next output.
    send(8);
    check("send_valid", 32'(data_valid_out), 32'h1);
    send(9);
    check("send_carry_no_strobe", 32'(data_valid_out), 32'h0);
    send(1);
    check("send_carry_valid", 32'(data_valid_out), 32'h1);
    check("send_carry_data", 32'(data_out), 32'h2000A);
    step();

    // An asynchronous reset mid-frame drops the partial sum.
    prog(4'd4);
    for (int i = 0; i < 5; i++) send(-1);
    #2 reset_n_in = 1'b0;
    #1;
    check("t6_rst_data", 32'(data_out), 32'h0);
    check("t6_rst_valid", 32'(data_valid_out), 32'h0);
    check("t6_rst_os", 32'(os_active_out), 32'h0);
    step();
    reset_n_in = 1'b1;
    step();
    prog(4'd4);
    check("t6_os", 32'(os_active_out), 32'h4);
    for (int i = 0; i < 15; i++) send(-1);
    check("t6_no_early", 32'(data_valid_out), 32'h0);
    send(-1);
    check("t6_valid", 32'(data_valid_out), 32'h1);
    check("t6_data", 32'(data_out), 32'h1FFFF);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
